i2s_tx: RTL and testbench

Serialises processed 24-bit stereo audio samples onto an I2S link to the codec DAC. Sits at the output end of the audio chain: it generates bit clock, word select and serial data from the system clock, and issues a one-cycle sample request that upstream effect blocks use as their per-sample `valid` strobe. Samples arrive as a parallel word with a `valid` strobe; missing samples are detected and reported as underruns.

---
 rtl/i2s_tx_if.sv | 19 +
 rtl/i2s_tx.sv | 100 ++++++++++
 tb/tb_i2s_tx.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: parallel sample handshake between the audio chain and i2s_tx.
// master = upstream sample source, slave = transmitter.
interface i2s_tx_if;
  logic        valid;
  logic [23:0] audio_l;
  logic [23:0] audio_r;
  logic        sample_req;
  logic        underrun;

  modport master (
    output valid, audio_l, audio_r,
    input  sample_req, underrun
  );

  modport slave (
    input  valid, audio_l, audio_r,
    output sample_req, underrun
  );
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: 24-bit stereo I2S transmitter, 64-bclk frames, sample request.
// Define I2S_TX_UNDERRUN_MUTE_EN to send silence instead of repeating on underrun.
module i2s_tx #(
  parameter int BCLK_DIV = 4
) (
  input  logic    clock,
  input  logic    resetn,
  i2s_tx_if.slave aud,
  output logic    bclk,
  output logic    lrclk,
  output logic    sdata
);
  localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

  logic [DW-1:0] dcnt;
  logic [5:0]    slot;
  logic          run;
  logic          pending;
  logic [23:0]   hold_l, hold_r;
  logic [23:0]   sh_l, sh_r;
  logic [23:0]   ld_l, ld_r;
  logic          tick, fe, frame_ld;
  logic [5:0]    nslot;
  logic [4:0]    j;

  assign tick     = (dcnt == DW'(BCLK_DIV - 1));
  assign fe       = tick & bclk;
  // run is clear until the first falling edge, which enters slot 0
  assign nslot    = run ? slot + 6'd1 : 6'd0;
  assign j        = nslot[4:0];
  assign frame_ld = fe & (nslot == 6'd0);

  always_comb begin
    ld_l = '0;
    ld_r = '0;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
    if (run && pending) begin
      ld_l = hold_l;
      ld_r = hold_r;
    end
`else
    if (run) begin
      ld_l = hold_l;
      ld_r = hold_r;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dcnt           <= '0;
      bclk           <= 1'b0;
      lrclk          <= 1'b0;
      sdata          <= 1'b0;
      slot           <= '0;
      run            <= 1'b0;
      pending        <= 1'b0;
      hold_l         <= '0;
      hold_r         <= '0;
      sh_l           <= '0;
      sh_r           <= '0;
      aud.sample_req <= 1'b0;
      aud.underrun   <= 1'b0;
    end else begin
      aud.sample_req <= 1'b0;
      aud.underrun   <= 1'b0;
      dcnt <= tick ? '0 : dcnt + 1'b1;
      if (tick)
        bclk <= ~bclk;
      if (aud.valid) begin
        hold_l <= aud.audio_l;
        hold_r <= aud.audio_r;
      end
      if (aud.valid)
        pending <= 1'b1;
      else if (frame_ld && run)
        pending <= 1'b0;
      if (fe) begin
        run            <= 1'b1;
        slot           <= nslot;
        lrclk          <= nslot[5];
        aud.sample_req <= (nslot == 6'd32);
        if (frame_ld) begin
          sh_l         <= ld_l;
          sh_r         <= ld_r;
          sdata        <= 1'b0;
          aud.underrun <= run & ~pending;
        end else if (j == 5'd0 || j > 5'd24) begin
          sdata <= 1'b0;
        end else if (nslot[5]) begin
          sdata <= sh_r[23];
          sh_r  <= {sh_r[22:0], 1'b0};
        end else begin
          sdata <= sh_l[23];
          sh_l  <= {sh_l[22:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for i2s_tx (frame decode monitor + cadence check).
// Honours I2S_TX_UNDERRUN_MUTE_EN for the expected underrun payload.
module tb_i2s_tx;
  localparam int BA = 4;
  localparam int BB = 2;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    bit          ur;
  } exp_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic resetn_b = 1'b0;
  logic bclk_a, lrclk_a, sdata_a;
  logic bclk_b, lrclk_b, sdata_b;

  i2s_tx_if ua ();
  i2s_tx_if ub ();

  i2s_tx #(.BCLK_DIV(BA)) dut_a (
    .clock (clock),
    .resetn(resetn),
    .aud   (ua),
    .bclk  (bclk_a),
    .lrclk (lrclk_a),
    .sdata (sdata_a)
  );

  i2s_tx #(.BCLK_DIV(BB)) dut_b (
    .clock (clock),
    .resetn(resetn_b),
    .aud   (ub),
    .bclk  (bclk_b),
    .lrclk (lrclk_b),
    .sdata (sdata_b)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  exp_t q[$];
  logic [23:0] hl, hr;
  bit done_b = 1'b0;
  bit rst_q = 1'b1;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [63:0] bits, lrs;
  int mslot, ur_cnt, ur_n;
  bit skip;
  logic pb, plr, psr;

  always @(posedge clock) rst_q = !resetn;

  task automatic eval_frame();
    exp_t e;
    logic [23:0] gl, gr;
    int pad, jj;
    gl = '0;
    gr = '0;
    pad = 0;
    for (int s = 0; s < 64; s++) begin
      jj = s % 32;
      if (lrs[s] !== ((s >= 32) ? 1'b1 : 1'b0)) pad++;
      if (jj >= 1 && jj <= 24) begin
        if (s < 32) gl[24-jj] = bits[s];
        else gr[24-jj] = bits[s];
      end else if (bits[s] !== 1'b0) begin
        pad++;
      end
    end
    if (q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL sb_empty: frame got L=%h R=%h with no expectation", gl, gr);
    end else begin
      e = q.pop_front();
      chk("frame_l", 32'(gl), 32'(e.l));
      chk("frame_r", 32'(gr), 32'(e.r));
      chk("framing", pad, 0);
      chk("underrun_cnt", ur_n, 32'(e.ur));
    end
  endtask

  always @(negedge clock) begin
    if (rst_q) begin
      q.delete();
      mslot  = 0;
      skip   = 1'b1;
      ur_cnt = 0;
      ur_n   = 0;
      pb     = 1'b0;
      plr    = 1'b0;
      psr    = 1'b0;
    end else begin
      if (ua.underrun) begin
        ur_cnt++;
        chk("ur_align", 32'({lrclk_a, plr, bclk_a, pb}), 32'b0101);
      end
      if (ua.sample_req)
        chk("req_align", 32'({lrclk_a, plr, bclk_a, pb, psr}), 32'b10010);
      if (bclk_a && !pb) begin
        if (skip) begin
          skip = 1'b0;
        end else begin
          if (mslot == 0) begin
            ur_n   = ur_cnt;
            ur_cnt = 0;
          end
          bits[mslot] = sdata_a;
          lrs[mslot]  = lrclk_a;
          mslot++;
          if (mslot == 64) begin
            mslot = 0;
            eval_frame();
          end
        end
      end
      pb  = bclk_a;
      plr = lrclk_a;
      psr = ua.sample_req;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(logic [23:0] l, logic [23:0] r, bit ur);
    exp_t e;
    e.l = l;
    e.r = r;
    e.ur = ur;
    q.push_back(e);
  endtask

  task automatic wait_req();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(negedge clock);
      ok = ua.sample_req;
    end
    if (!ok) begin
      n_chk++;
      n_err++;
      $display("FAIL req_timeout: sample_req=0 after 1000 cycles, need 1");
    end
  endtask

  task automatic send(logic [23:0] l, logic [23:0] r);
    @(negedge clock);
    ua.valid   = 1'b1;
    ua.audio_l = l;
    ua.audio_r = r;
    @(negedge clock);
    ua.valid   = 1'b0;
  endtask

  task automatic serve(logic [23:0] l, logic [23:0] r);
    wait_req();
    send(l, r);
    hl = l;
    hr = r;
    push(l, r, 1'b0);
  endtask

  task automatic serve_none();
    wait_req();
    push(MUTE ? 24'd0 : hl, MUTE ? 24'd0 : hr, 1'b1);
  endtask

  task automatic check_restart();
    int bad;
    bad = 0;
    for (int k = 1; k <= 4 * BA; k++) begin
      @(negedge clock);
      if (bclk_a !== 1'(((k / BA) % 2))) bad++;
    end
    chk("bclk_cadence", bad, 0);
  endtask

  initial begin
    ua.valid = 1'b0;
    ua.audio_l = '0;
    ua.audio_r = '0;
    ub.valid = 1'b0;
    ub.audio_l = '0;
    ub.audio_r = '0;
    hl = '0;
    hr = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_out",
        32'({bclk_a, lrclk_a, sdata_a, ua.sample_req, ua.underrun}), 0);
    resetn = 1'b1;
    check_restart();
    push(24'd0, 24'd0, 1'b0);

    serve(24'h800001, 24'h7FFFFE);
    serve(24'h123456, 24'h654321);
    serve_none();

    // two valids in one frame: the later one wins
    wait_req();
    send(24'h000001, 24'h000011);
    repeat (10) @(negedge clock);
    send(24'h000002, 24'h000022);
    hl = 24'h000002;
    hr = 24'h000022;
    push(hl, hr, 1'b0);

    // valid coincident with the frame-load falling edge
    serve_none();
    repeat (64 * BA - 2) @(negedge clock);
    send(24'hABCDEF, 24'hFEDCBA);
    hl = 24'hABCDEF;
    hr = 24'hFEDCBA;
    wait_req();
    push(hl, hr, 1'b0);

    serve_none();

    // mid-frame reset around slot 40
    wait_req();
    repeat (16 * BA) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    chk("midreset_out",
        32'({bclk_a, lrclk_a, sdata_a, ua.sample_req, ua.underrun}), 0);
    resetn = 1'b1;
    check_restart();
    hl = '0;
    hr = '0;
    push(24'd0, 24'd0, 1'b0);
    serve(24'h5A5A5A, 24'hA5A5A5);
    serve_none();

    for (int n = 0; n < 3000 && q.size() > 0; n++) @(negedge clock);
    chk("sb_drain", q.size(), 0);
    for (int n = 0; n < 5000 && !done_b; n++) @(negedge clock);
    chk("cadence_done", 32'(done_b), 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // request cadence on the BCLK_DIV=2 instance
  initial begin
    int k;
    bit got;
    resetn_b = 1'b0;
    repeat (2) @(negedge clock);
    resetn_b = 1'b1;
    k = 0;
    got = 1'b0;
    while (k < 1000 && !got) begin
      @(negedge clock);
      k++;
      got = ub.sample_req;
    end
    chk("req_first", k, 2 * BB + 64 * BB);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("req_width", 32'(ub.sample_req), 0);
      k = 1;
      got = 1'b0;
      while (k < 1000 && !got) begin
        @(negedge clock);
        k++;
        got = ub.sample_req;
      end
      chk("req_period", k, 128 * BB);
    end
    done_b = 1'b1;
  end
endmodule
